// File: rtl/xor_fold_sig.sv
// Per-channel XOR fold of IN_W-bit words down to OUT_W bits, either per beat or
// as a running signature over a frame, behind a single registered output stage.
module xor_fold_sig #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned CH    = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*IN_W-1:0]    in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH*OUT_W-1:0]   out_data,
    output logic [CNT_W-1:0]      out_cnt,
    output logic                  busy
);

    localparam int unsigned SLICES = IN_W / OUT_W;
    localparam int unsigned DW     = CH * OUT_W;

    generate
        if (OUT_W == 0 || (IN_W % OUT_W) != 0) begin : g_bad_width
            $error("xor_fold_sig: IN_W must be a non-zero multiple of OUT_W");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t            state;
    logic              m_q;
    logic [DW-1:0]     acc;
    logic [CNT_W-1:0]  cnt;

    logic [DW-1:0]     fold_in;
    logic [CNT_W-1:0]  cnt_inc;
    logic              accept;

    // XOR all OUT_W-bit slices of each channel word together
    function automatic logic [DW-1:0] fold(input logic [CH*IN_W-1:0] x);
        logic [DW-1:0] r;
        r = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            for (int unsigned k = 0; k < SLICES; k++) begin
                r[c*OUT_W +: OUT_W] = r[c*OUT_W +: OUT_W] ^ x[c*IN_W + k*OUT_W +: OUT_W];
            end
        end
        return r;
    endfunction

    assign fold_in  = fold(in_data);
    assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ACC) || out_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            m_q       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
        end else begin
            // a transfer empties the slot unless a new result lands below
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                case (state)
                    IDLE: begin
                        m_q <= mode;
                        if (!mode || in_last) begin
                            out_data  <= fold_in;
                            out_cnt   <= CNT_W'(1);
                            out_valid <= 1'b1;
                        end else begin
                            acc   <= fold_in;
                            cnt   <= CNT_W'(1);
                            state <= ACC;
                        end
                    end
                    ACC: begin
                        // frame was opened in accumulate mode; mode input is ignored here
                        if (in_last || !m_q) begin
                            out_data  <= acc ^ fold_in;
                            out_cnt   <= cnt_inc;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= IDLE;
                        end else begin
                            acc <= acc ^ fold_in;
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xor_fold_sig.sv
// Bench for xor_fold_sig: directed scenarios plus randomized traffic checked
// against a frame-level reference model (default CNT_W and a CNT_W=4 copy).
module tb_xor_fold_sig;

    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned CH    = 2;
    localparam int unsigned IW    = CH * IN_W;
    localparam int unsigned DW    = CH * OUT_W;

    logic          clk;
    logic          rst_n;
    logic          mode;
    logic          in_valid;
    logic          in_last;
    logic          out_ready;
    logic [IW-1:0] in_data;

    logic          in_ready, out_valid, busy;
    logic [DW-1:0] out_data;
    logic [7:0]    out_cnt;
    logic          in_ready4, out_valid4, busy4;
    logic [DW-1:0] out_data4;
    logic [3:0]    out_cnt4;

    int checks;
    int failures;

    // reference model state
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    int            exp_n;
    logic          in_frame;
    logic [IW-1:0] frame_q[$];

    xor_fold_sig #(.IN_W(IN_W), .OUT_W(OUT_W), .CH(CH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cnt(out_cnt), .busy(busy)
    );

    xor_fold_sig #(.IN_W(IN_W), .OUT_W(OUT_W), .CH(CH), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .out_cnt(out_cnt4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fold by shifting and masking whole words
    function automatic logic [DW-1:0] ref_fold(input logic [IW-1:0] x);
        logic [DW-1:0] r;
        logic [IW-1:0] w;
        logic [IW-1:0] mask;
        r    = '0;
        mask = (IW'(1) << OUT_W) - IW'(1);
        for (int c = 0; c < int'(CH); c++) begin
            w = x >> (c * int'(IN_W));
            for (int k = 0; k < int'(IN_W / OUT_W); k++) begin
                r = r ^ DW'(((w >> (k * int'(OUT_W))) & mask) << (c * int'(OUT_W)));
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] sat8(input int n);
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    function automatic logic [3:0] sat4(input int n);
        return (n > 15) ? 4'd15 : 4'(n);
    endfunction

    // advance one clock and update the model from what was presented at the edge
    task automatic step();
        logic          take;
        logic [DW-1:0] sig;
        take = rst_n && in_valid && (!exp_valid || out_ready);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_n     = 0;
            in_frame  = 1'b0;
            frame_q.delete();
            return;
        end
        if (exp_valid && out_ready) exp_valid = 1'b0;
        if (take) begin
            if (!in_frame) begin
                if (!mode || in_last) begin
                    exp_valid = 1'b1;
                    exp_data  = ref_fold(in_data);
                    exp_n     = 1;
                end else begin
                    in_frame = 1'b1;
                    frame_q.delete();
                    frame_q.push_back(in_data);
                end
            end else begin
                frame_q.push_back(in_data);
                if (in_last) begin
                    sig = '0;
                    foreach (frame_q[i]) sig = sig ^ ref_fold(frame_q[i]);
                    exp_valid = 1'b1;
                    exp_data  = sig;
                    exp_n     = frame_q.size();
                    in_frame  = 1'b0;
                    frame_q.delete();
                end
            end
        end
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl: got v=%b busy=%b rdy=%b expected 0 0 1", out_valid, busy, in_ready);
        end
        checks++;
        if (out_data !== '0 || out_cnt !== 8'd0 || out_cnt4 !== 4'd0) begin
            failures++;
            $display("FAIL reset_data: got data=%h cnt=%0d cnt4=%0d expected 0 0 0", out_data, out_cnt, out_cnt4);
        end
    endtask

    task automatic test_fold_vector();
        idle_inputs();
        in_valid = 1'b1;
        in_data  = {16'hA5C3, 16'h1234};
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h6626 || out_cnt !== 8'd1) begin
            failures++;
            $display("FAIL fold_vector: got v=%b data=%h cnt=%0d expected 1 6626 1", out_valid, out_data, out_cnt);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fold_drain: got v=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_accumulate();
        logic [15:0] beats [3];
        beats[0] = 16'h0102;
        beats[1] = 16'h0408;
        beats[2] = 16'h1020;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            mode     = (i == 0);
            in_last  = (i == 2);
            in_data  = {16'h0000, beats[i]};
            step();
            checks++;
            if (busy !== 1'b1 || out_valid !== (i == 2)) begin
                failures++;
                $display("FAIL acc_beat%0d: got v=%b busy=%b expected %b 1", i, out_valid, busy, (i == 2));
            end
        end
        idle_inputs();
        checks++;
        if (out_data !== 16'h003F || out_cnt !== 8'd3) begin
            failures++;
            $display("FAIL acc_result: got data=%h cnt=%0d expected 003f 3", out_data, out_cnt);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] held;
        idle_inputs();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = IW'($urandom);
        step();
        held    = ref_fold(in_data);
        in_data = IW'($urandom);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready%0d: got %b expected 0", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || out_cnt !== 8'd1) begin
                failures++;
                $display("FAIL bp_hold%0d: got v=%b data=%h cnt=%0d expected 1 %h 1", i, out_valid, out_data, out_cnt, held);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: got in_ready=%b expected 1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_data || exp_data !== ref_fold(in_data)) begin
            failures++;
            $display("FAIL bp_swap: got v=%b data=%h expected 1 %h", out_valid, out_data, ref_fold(in_data));
        end
        for (int i = 0; i < 10; i++) begin
            in_data = IW'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== ref_fold(in_data) || out_cnt !== 8'd1) begin
                failures++;
                $display("FAIL b2b%0d: got v=%b data=%h cnt=%0d expected 1 %h 1", i, out_valid, out_data, out_cnt, ref_fold(in_data));
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_saturation();
        int lens [2];
        lens[0] = 20;
        lens[1] = 21;
        for (int f = 0; f < 2; f++) begin
            idle_inputs();
            for (int i = 0; i < lens[f]; i++) begin
                in_valid = 1'b1;
                mode     = 1'b1;
                in_last  = (i == lens[f] - 1);
                in_data  = {16'h0000, 16'h0001};
                step();
            end
            idle_inputs();
            checks++;
            if (out_valid4 !== 1'b1 || out_cnt4 !== 4'd15 || out_data4 !== DW'(f)) begin
                failures++;
                $display("FAIL sat4_len%0d: got v=%b cnt=%0d data=%h expected 1 15 %h", lens[f], out_valid4, out_cnt4, out_data4, DW'(f));
            end
            checks++;
            if (out_cnt !== sat8(lens[f]) || out_data !== DW'(f) || busy4 !== 1'b1 || in_ready4 !== 1'b1) begin
                failures++;
                $display("FAIL sat8_len%0d: got cnt=%0d data=%h expected %0d %h", lens[f], out_cnt, out_data, lens[f], DW'(f));
            end
            step();
        end
    endtask

    task automatic test_reset_mid_frame();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            mode     = 1'b1;
            in_data  = IW'($urandom);
            step();
        end
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: got v=%b busy=%b expected 0 0", out_valid, busy);
        end
        in_valid = 1'b1;
        mode     = 1'b1;
        in_last  = 1'b1;
        in_data  = {16'h0000, 16'hFF00};
        step();
        idle_inputs();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h00FF || out_cnt !== 8'd1) begin
            failures++;
            $display("FAIL rst_residue: got v=%b data=%h cnt=%0d expected 1 00ff 1", out_valid, out_data, out_cnt);
        end
        step();
    endtask

    task automatic test_mode_toggle();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            mode     = (i == 0);
            in_last  = (i == 4);
            in_data  = IW'($urandom);
            step();
            checks++;
            if (out_valid !== (i == 4)) begin
                failures++;
                $display("FAIL toggle_beat%0d: got v=%b expected %b", i, out_valid, (i == 4));
            end
        end
        idle_inputs();
        checks++;
        if (out_data !== exp_data || out_cnt !== 8'd5 || exp_n != 5) begin
            failures++;
            $display("FAIL toggle_result: got data=%h cnt=%0d expected %h 5", out_data, out_cnt, exp_data);
        end
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            mode      = $urandom_range(0, 1) == 1;
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = IW'($urandom);
            #1;
            checks++;
            if (in_ready !== (!exp_valid || out_ready)) begin
                failures++;
                $display("FAIL rnd_ready%0d: got %b expected %b", i, in_ready, (!exp_valid || out_ready));
            end
            step();
            checks++;
            if (out_valid !== exp_valid || busy !== (exp_valid || in_frame)) begin
                failures++;
                $display("FAIL rnd_ctrl%0d: got v=%b busy=%b expected %b %b", i, out_valid, busy, exp_valid, (exp_valid || in_frame));
            end
            if (exp_valid) begin
                checks++;
                if (out_data !== exp_data || out_cnt !== sat8(exp_n) || out_cnt4 !== sat4(exp_n)) begin
                    failures++;
                    $display("FAIL rnd_data%0d: got data=%h cnt=%0d cnt4=%0d expected %h %0d %0d",
                             i, out_data, out_cnt, out_cnt4, exp_data, sat8(exp_n), sat4(exp_n));
                end
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_n     = 0;
        in_frame  = 1'b0;
        rst_n     = 1'b0;
        idle_inputs();
        test_reset();
        test_fold_vector();
        test_accumulate();
        test_back_to_back();
        test_saturation();
        test_reset_mid_frame();
        test_mode_toggle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
